// File: rtl/operand_pickup_ctrl.sv
// Operand pickup sequencer: hides hit operands for a frame-counted cooldown and
// hands each accepted hit to the score unit over a round-robin req/ack handshake.
module operand_pickup_ctrl #(
  parameter int HIDE_FRAMES = 450,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             gameOn,
  input  logic [1:0]       hitIn,
  input  logic             opAck,
  output logic [1:0]       showOperand,
  output logic             opReq,
  output logic             opSel,
  output logic [CNT_W-1:0] hitCount
);

  localparam int                 TIMER_W   = 10;
  localparam int                 SUM_W     = CNT_W + 2;
  localparam logic [TIMER_W-1:0] HIDE_LOAD = TIMER_W'(HIDE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               show_q, show_d;
  logic [1:0]               pending_q, pending_d;
  logic [1:0][TIMER_W-1:0]  timer_q, timer_d;
  logic                     rr_q, rr_d;
  logic                     req_q, req_d;
  logic                     sel_q, sel_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [SUM_W-1:0]         count_sum;
  logic [1:0]               accept;
  logic                     frame_tick;
  logic                     serve_done;
  logic                     grant;

  assign accept     = hitIn & {2{gameOn}} & show_q;
  assign frame_tick = startOfFrame & gameOn;
  assign serve_done = (state_q == ST_REQ) & opAck;
  // With both pending the RR pointer names the index not served last.
  assign grant      = (pending_q == 2'b11) ? rr_q : pending_q[1];

  // An operand only reappears once its cooldown expired and its operation was serviced.
  always_comb begin
    show_d    = show_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    if (serve_done) begin
      pending_d[sel_q] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) begin
        show_d[i]    = 1'b0;
        timer_d[i]   = HIDE_LOAD;
        pending_d[i] = 1'b1;
      end else begin
        if (frame_tick && (timer_q[i] != '0)) begin
          timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
        if ((timer_q[i] == '0) && !pending_q[i]) begin
          show_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_sum = SUM_W'(count_q) + SUM_W'(accept[0]) + SUM_W'(accept[1]);
    count_d   = (count_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 2'b00) begin
          req_d   = 1'b1;
          sel_d   = grant;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (opAck) begin
          req_d   = 1'b0;
          rr_d    = ~sel_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      show_q    <= 2'b11;
      pending_q <= 2'b00;
      timer_q   <= '0;
      rr_q      <= 1'b0;
      req_q     <= 1'b0;
      sel_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      show_q    <= show_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      rr_q      <= rr_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
    end
  end

  assign showOperand = show_q;
  assign opReq       = req_q;
  assign opSel       = sel_q;
  assign hitCount    = count_q;

endmodule

// File: tb/tb_operand_pickup_ctrl.sv
// Bench for operand_pickup_ctrl: vector table, directed corner sequences and
// random traffic against a spec-level model; a second fast-cooldown instance covers counter saturation.
module tb_operand_pickup_ctrl;

  localparam int HIDE      = 450;
  localparam int FAST_HIDE = 5;
  localparam int CMAX      = 255;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0, sof = 1'b0, game_on = 1'b0, ack = 1'b0;
  logic [1:0] hit = 2'b00;
  logic [1:0] show;
  logic       req, sel;
  logic [7:0] count;

  logic       f_reset_n = 1'b0, f_sof = 1'b0, f_ack = 1'b0;
  logic [1:0] f_hit = 2'b00;
  logic [1:0] f_show;
  logic       f_req, f_sel;
  logic [7:0] f_count;

  operand_pickup_ctrl #(.HIDE_FRAMES(HIDE), .CNT_W(8)) dut (
    .clk(clk), .resetN(reset_n), .startOfFrame(sof), .gameOn(game_on),
    .hitIn(hit), .opAck(ack), .showOperand(show), .opReq(req), .opSel(sel),
    .hitCount(count)
  );

  operand_pickup_ctrl #(.HIDE_FRAMES(FAST_HIDE), .CNT_W(8)) dut_fast (
    .clk(clk), .resetN(f_reset_n), .startOfFrame(f_sof), .gameOn(1'b1),
    .hitIn(f_hit), .opAck(f_ack), .showOperand(f_show), .opReq(f_req), .opSel(f_sel),
    .hitCount(f_count)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: per-operand visibility, cooldown, owed operation, plus the request in flight.
  int m_show[2], m_timer[2], m_pend[2];
  int m_rr, m_req, m_sel, m_count;

  typedef struct {
    bit       r, s, g;
    bit [1:0] h;
    bit       a;
    bit [1:0] e_show;
    bit       e_req, e_sel;
    int       e_count;
  } vec_t;

  task automatic cmp(string name, int got, int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic modelStep(bit r, bit s, bit g, bit [1:0] h, bit a);
    int acc[2], nshow[2], ntimer[2], npend[2];
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_show[i] = 1; m_timer[i] = 0; m_pend[i] = 0;
      end
      m_rr = 0; m_req = 0; m_sel = 0; m_count = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      acc[i] = (h[i] && g && m_show[i] == 1) ? 1 : 0;
      if (acc[i] == 1) begin
        nshow[i] = 0; ntimer[i] = HIDE; npend[i] = 1;
      end else begin
        nshow[i]  = (m_timer[i] == 0 && m_pend[i] == 0) ? 1 : m_show[i];
        ntimer[i] = (s && g && m_timer[i] > 0) ? m_timer[i] - 1 : m_timer[i];
        npend[i]  = (m_req == 1 && a && m_sel == i) ? 0 : m_pend[i];
      end
    end
    m_count = m_count + acc[0] + acc[1];
    if (m_count > CMAX) m_count = CMAX;
    if (m_req == 1) begin
      if (a) begin
        m_req = 0;
        m_rr  = 1 - m_sel;
      end
    end else if (m_pend[0] == 1 || m_pend[1] == 1) begin
      m_req = 1;
      m_sel = (m_pend[0] == 1 && m_pend[1] == 1) ? m_rr : m_pend[1];
    end
    for (int i = 0; i < 2; i++) begin
      m_show[i] = nshow[i]; m_timer[i] = ntimer[i]; m_pend[i] = npend[i];
    end
  endtask

  task automatic applyStimulus(bit r, bit s, bit g, bit [1:0] h, bit a);
    reset_n = r; sof = s; game_on = g; hit = h; ack = a;
    @(posedge clk);
    modelStep(r, s, g, h, a);
    @(negedge clk);
  endtask

  task automatic checkOutput(string tag, bit [1:0] e_show, bit e_req, bit e_sel, int e_count);
    cmp({tag, ".show"}, int'(show), int'(e_show));
    cmp({tag, ".req"}, int'(req), int'(e_req));
    cmp({tag, ".sel"}, int'(sel), int'(e_sel));
    cmp({tag, ".count"}, int'(count), e_count);
  endtask

  task automatic run(string tag, bit r, bit s, bit g, bit [1:0] h, bit a);
    bit [1:0] es;
    applyStimulus(r, s, g, h, a);
    es = {m_show[1] == 1, m_show[0] == 1};
    checkOutput(tag, es, m_req == 1, m_sel == 1, m_count);
  endtask

  task automatic fastCycle(bit r, bit s, bit [1:0] h, bit a);
    f_reset_n = r; f_sof = s; f_hit = h; f_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    tbl.push_back('{0,0,1,2'b00,0, 2'b11,0,0,0});
    tbl.push_back('{1,0,1,2'b00,0, 2'b11,0,0,0});
    tbl.push_back('{1,0,1,2'b01,0, 2'b10,0,0,1});
    tbl.push_back('{1,0,1,2'b00,0, 2'b10,1,0,1});
    tbl.push_back('{1,0,1,2'b00,0, 2'b10,1,0,1});
    tbl.push_back('{1,0,1,2'b00,1, 2'b10,0,0,1});
    tbl.push_back('{1,0,1,2'b00,1, 2'b10,0,0,1});
    tbl.push_back('{1,0,1,2'b11,0, 2'b00,0,0,2});
    tbl.push_back('{1,0,1,2'b00,0, 2'b00,1,1,2});
    tbl.push_back('{1,1,1,2'b00,1, 2'b00,0,1,2});
    tbl.push_back('{1,0,1,2'b00,0, 2'b00,0,1,2});
    tbl.push_back('{0,0,1,2'b00,0, 2'b11,0,0,0});
    tbl.push_back('{1,0,1,2'b11,0, 2'b00,0,0,2});
    tbl.push_back('{1,0,1,2'b00,0, 2'b00,1,0,2});
    tbl.push_back('{1,0,1,2'b00,1, 2'b00,0,0,2});
    tbl.push_back('{1,0,1,2'b00,0, 2'b00,1,1,2});
    tbl.push_back('{1,0,1,2'b00,1, 2'b00,0,1,2});
    tbl.push_back('{0,0,0,2'b00,0, 2'b11,0,0,0});
    tbl.push_back('{1,1,0,2'b11,0, 2'b11,0,0,0});
    tbl.push_back('{1,0,1,2'b10,0, 2'b01,0,0,1});
    tbl.push_back('{1,0,1,2'b00,0, 2'b01,1,1,1});
    tbl.push_back('{0,0,1,2'b00,0, 2'b11,0,0,0});

    for (int k = 0; k < tbl.size(); k++) begin
      applyStimulus(tbl[k].r, tbl[k].s, tbl[k].g, tbl[k].h, tbl[k].a);
      checkOutput($sformatf("vec%0d", k), tbl[k].e_show, tbl[k].e_req, tbl[k].e_sel, tbl[k].e_count);
    end

    // Single plus hit, cooldown of exactly HIDE frames, then round-robin with pointer at minus.
    run("A.rst", 0, 0, 1, 2'b00, 0);
    run("A.hit", 1, 0, 1, 2'b01, 0);
    run("A.req", 1, 0, 1, 2'b00, 0);
    run("A.ack", 1, 0, 1, 2'b00, 1);
    for (int k = 0; k < HIDE; k++) run("A.frame", 1, 1, 1, 2'b00, 0);
    cmp("A.hidden_at_last_frame", int'(show[0]), 0);
    run("A.idle", 1, 0, 1, 2'b00, 0);
    cmp("A.reshow", int'(show), 3);
    cmp("A.count", int'(count), 1);
    run("A.both", 1, 0, 1, 2'b11, 0);
    cmp("A.count_both", int'(count), 3);
    run("A.req1", 1, 0, 1, 2'b00, 0);
    cmp("A.rr_minus_first", int'({req, sel}), 3);
    run("A.ack1", 1, 0, 1, 2'b00, 1);
    cmp("A.req_low_between", int'(req), 0);
    run("A.req2", 1, 0, 1, 2'b00, 0);
    cmp("A.rr_plus_second", int'({req, sel}), 2);
    run("A.ack2", 1, 0, 1, 2'b00, 1);

    // Hit on a hidden operand must not reload its cooldown.
    for (int k = 0; k < 100; k++) run("B.frame", 1, 1, 1, 2'b00, 0);
    run("B.hidden_hit", 1, 0, 1, 2'b10, 0);
    cmp("B.hidden_hit_ignored", int'(count), 3);
    for (int k = 0; k < HIDE - 100; k++) run("B.frame2", 1, 1, 1, 2'b00, 0);
    run("B.idle", 1, 0, 1, 2'b00, 0);
    cmp("B.original_schedule", int'(show), 3);

    // Ack withheld well past the cooldown: operand stays hidden until serviced.
    run("C.hit", 1, 0, 1, 2'b01, 0);
    run("C.req", 1, 0, 1, 2'b00, 0);
    for (int k = 0; k < 600; k++) run("C.wait", 1, 1, 1, 2'b00, 0);
    cmp("C.req_held", int'({req, sel}), 2);
    cmp("C.still_hidden", int'(show[0]), 0);
    run("C.ack", 1, 0, 1, 2'b00, 1);
    cmp("C.req_dropped", int'(req), 0);
    cmp("C.hidden_at_ack", int'(show[0]), 0);
    run("C.idle", 1, 0, 1, 2'b00, 0);
    cmp("C.reshow_after_ack", int'(show), 3);

    // gameOn low: hits ignored, timers frozen, handshake still drains.
    run("D.hit", 1, 0, 1, 2'b01, 0);
    run("D.req", 1, 0, 1, 2'b00, 0);
    for (int k = 0; k < 10; k++) run("D.off", 1, 1, 0, 2'b11, 0);
    cmp("D.count_frozen", int'(count), 5);
    cmp("D.show_frozen", int'(show), 2);
    run("D.ack_off", 1, 0, 0, 2'b00, 1);
    cmp("D.drain_while_off", int'(req), 0);
    for (int k = 0; k < HIDE - 1; k++) run("D.frame", 1, 1, 1, 2'b00, 0);
    cmp("D.frozen_timer", int'(show[0]), 0);
    run("D.last", 1, 1, 1, 2'b00, 0);
    run("D.idle", 1, 0, 1, 2'b00, 0);
    cmp("D.reshow", int'(show), 3);

    for (int k = 0; k < 3000; k++) begin
      bit       r, s, g, a;
      bit [1:0] h;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 1) == 1);
      g = ($urandom_range(0, 9) != 0);
      h = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      a = ($urandom_range(0, 2) == 0);
      run("R", r, s, g, h, a);
    end

    // Saturation of the hit counter on the short-cooldown instance.
    fastCycle(0, 0, 2'b00, 0);
    cmp("E.reset_count", int'(f_count), 0);
    for (int rnd = 1; rnd <= 130; rnd++) begin
      bit done;
      int exp_cnt;
      fastCycle(1, 0, 2'b11, 0);
      exp_cnt = (2 * rnd > CMAX) ? CMAX : 2 * rnd;
      cmp($sformatf("E.count_r%0d", rnd), int'(f_count), exp_cnt);
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        fastCycle(1, 1, 2'b00, f_req);
        if (f_show == 2'b11 && !f_req) done = 1'b1;
      end
      cmp($sformatf("E.drained_r%0d", rnd), int'(done), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
